// File: rtl/mips_mc_control_if.sv
// mips_mc_control_if
// Bundles the controller <-> datapath/memory signals of the MIPS multi-cycle
// core.
//   slave  : controller view (opcode/zero/mem_ready in, strobes/selects out)
//   master : datapath view (drives opcode/zero/mem_ready, observes the rest)
interface mips_mc_control_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       iord;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       pc_en;
  logic       instr_done;
  logic       illegal_op;
  logic [3:0] state;

  modport slave (
    input  opcode, zero, mem_ready,
    output mem_read, mem_write, ir_write, iord, alu_src_a, alu_src_b,
           alu_op, pc_source, reg_dst, mem_to_reg, reg_write, pc_en,
           instr_done, illegal_op, state
  );

  modport master (
    output opcode, zero, mem_ready,
    input  mem_read, mem_write, ir_write, iord, alu_src_a, alu_src_b,
           alu_op, pc_source, reg_dst, mem_to_reg, reg_write, pc_en,
           instr_done, illegal_op, state
  );
endinterface

// File: rtl/mips_mc_control.sv
// mips_mc_control
// Main control FSM of the MIPS multi-cycle processor. Steps each instruction
// through fetch/decode/execute/memory/write-back, drives datapath selects and
// enables, and stalls on mem_ready in FETCH, MEMRD and MEMWR.
// Ports:
//   clk_i-style plain clock   clk : rising-edge system clock
//   rst                           : asynchronous active-high reset
//   bus (mips_mc_control_if.slave): opcode/zero/mem_ready in, controls out
// Build option: MIPS_MC_BNE_EN adds bne (opcode 000101) sharing the BRANCH
// state; undefined, that opcode is illegal.
//
// state  | meaning
// FETCH  | read instruction at PC, PC += 4 on mem_ready
// DECODE | precompute branch target, dispatch on opcode
// MEMADR | compute lw/sw address
// MEMRD  | load data read, wait for mem_ready
// MEMWB  | write loaded data to rt
// MEMWR  | store write, wait for mem_ready
// REXE   | R-type ALU operation
// RWB    | R-type write-back to rd
// BRANCH | compare and conditionally load branch target
// JUMP   | load jump target
// IEXE   | addi ALU operation
// IWB    | addi write-back to rt
module mips_mc_control (
  input  logic                 clk,
  input  logic                 rst,
  mips_mc_control_if.slave     bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  REXE   = 4'd6,  RWB    = 4'd7,
    BRANCH = 4'd8,  JUMP   = 4'd9,  IEXE   = 4'd10, IWB    = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BNE  = 6'b000101;

  state_t state_q, state_d;

  logic       mem_read, mem_write, ir_write, iord, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       reg_dst, mem_to_reg, reg_write, instr_done, illegal_op;
  logic       pc_write, pc_write_cond, branch_taken;

`ifdef MIPS_MC_BNE_EN
  // Remembers whether BRANCH was reached through bne rather than beq.
  logic is_bne_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   is_bne_q <= 1'b0;
    else if (state_q == DECODE) is_bne_q <= (bus.opcode == OP_BNE);
  end

  assign branch_taken = is_bne_q ? ~bus.zero : bus.zero;
`else
  assign branch_taken = bus.zero;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    iord          = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;

    unique case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        ir_write  = bus.mem_ready;
        alu_src_b = 2'b01;
        pc_write  = bus.mem_ready;
        if (bus.mem_ready) state_d = DECODE;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYP:      state_d = REXE;
          OP_BEQ:       state_d = BRANCH;
`ifdef MIPS_MC_BNE_EN
          OP_BNE:       state_d = BRANCH;
`endif
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = IEXE;
          default: begin
            state_d    = FETCH;
            illegal_op = 1'b1;
            instr_done = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (bus.mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (bus.mem_ready) begin
          instr_done = 1'b1;
          state_d    = FETCH;
        end
      end
      REXE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = RWB;
      end
      RWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_source     = 2'b01;
        pc_write_cond = 1'b1;
        instr_done    = 1'b1;
        state_d       = FETCH;
      end
      JUMP: begin
        pc_source  = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      IEXE: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = IWB;
      end
      IWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // Reset masks every output so nothing is strobed while the core is held.
  assign bus.mem_read   = ~rst & mem_read;
  assign bus.mem_write  = ~rst & mem_write;
  assign bus.ir_write   = ~rst & ir_write;
  assign bus.iord       = ~rst & iord;
  assign bus.alu_src_a  = ~rst & alu_src_a;
  assign bus.alu_src_b  = rst ? 2'b00 : alu_src_b;
  assign bus.alu_op     = rst ? 2'b00 : alu_op;
  assign bus.pc_source  = rst ? 2'b00 : pc_source;
  assign bus.reg_dst    = ~rst & reg_dst;
  assign bus.mem_to_reg = ~rst & mem_to_reg;
  assign bus.reg_write  = ~rst & reg_write;
  assign bus.pc_en      = ~rst & (pc_write | (pc_write_cond & branch_taken));
  assign bus.instr_done = ~rst & instr_done;
  assign bus.illegal_op = ~rst & illegal_op;
  assign bus.state      = rst ? 4'd0 : state_q;

endmodule

// File: tb/tb_mips_mc_control.sv
module tb_mips_mc_control;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  mips_mc_control_if bus ();

  mips_mc_control dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int lw_st[6]   = '{0, 1, 2, 3, 4, 0};
    int lw_rw[6]   = '{0, 0, 0, 0, 1, 0};
    int lw_done[6] = '{0, 0, 0, 0, 1, 0};
    int done_cnt;

    rst = 1'b1;
    bus.opcode = 6'd0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;

    // reset state
    @(negedge clk);
    chk("rst_state", bus.state, 0);
    chk("rst_mem_read", bus.mem_read, 0);
    chk("rst_ir_write", bus.ir_write, 0);
    chk("rst_pc_en", bus.pc_en, 0);
    chk("rst_alu_src_b", bus.alu_src_b, 0);

    // lw, no stalls
    rst = 1'b0;
    bus.opcode = 6'b100011;
    #1;
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      chk($sformatf("lw_state%0d", i), bus.state, lw_st[i]);
      chk($sformatf("lw_reg_write%0d", i), bus.reg_write, lw_rw[i]);
      chk($sformatf("lw_done%0d", i), bus.instr_done, lw_done[i]);
      if (bus.instr_done) done_cnt++;
      if (i == 0) begin
        chk("lw_fetch_mem_read", bus.mem_read, 1);
        chk("lw_fetch_pc_en", bus.pc_en, 1);
        chk("lw_fetch_alu_src_b", bus.alu_src_b, 1);
      end
      if (i == 2) chk("lw_memadr_alu_src_b", bus.alu_src_b, 2);
      if (i == 4) chk("lw_mem_to_reg", bus.mem_to_reg, 1);
    end
    chk("lw_done_count", done_cnt, 1);

    // reset in the middle of MEMRD
    step(); step();
    chk("rmid_memadr", bus.state, 2);
    bus.mem_ready = 1'b0;
    step();
    chk("rmid_memrd", bus.state, 3);
    chk("rmid_memrd_iord", bus.iord, 1);
    step();
    chk("rmid_memrd_hold", bus.state, 3);
    chk("rmid_memrd_read", bus.mem_read, 1);
    rst = 1'b1;
    #1;
    chk("rmid_state", bus.state, 0);
    chk("rmid_mem_read", bus.mem_read, 0);
    chk("rmid_reg_write", bus.reg_write, 0);
    chk("rmid_iord", bus.iord, 0);
    step();
    chk("rmid_held_state", bus.state, 0);
    rst = 1'b0;
    #1;
    chk("rmid_rel_state", bus.state, 0);
    chk("rmid_rel_mem_read", bus.mem_read, 1);

    // fetch stall then R-type: 3 stall + 4 = 7 cycles
    bus.opcode = 6'b000000;
    chk("stall1_ir", bus.ir_write, 0);
    chk("stall1_pc", bus.pc_en, 0);
    step();
    chk("stall2_state", bus.state, 0);
    chk("stall2_ir", bus.ir_write, 0);
    step();
    chk("stall3_state", bus.state, 0);
    chk("stall3_pc", bus.pc_en, 0);
    step();
    bus.mem_ready = 1'b1;
    #1;
    chk("stall_go_ir", bus.ir_write, 1);
    chk("stall_go_pc", bus.pc_en, 1);
    step();
    chk("r_decode", bus.state, 1);
    chk("r_decode_ir", bus.ir_write, 0);
    chk("r_decode_alu_src_b", bus.alu_src_b, 3);
    step();
    chk("r_rexe", bus.state, 6);
    chk("r_rexe_alu_op", bus.alu_op, 2);
    step();
    chk("r_rwb", bus.state, 7);
    chk("r_rwb_reg_dst", bus.reg_dst, 1);
    chk("r_rwb_done", bus.instr_done, 1);
    step();
    chk("r_back_fetch", bus.state, 0);

    // beq both ways
    bus.opcode = 6'b000100;
    step(); step();
    chk("beq_state", bus.state, 8);
    bus.zero = 1'b1;
    #1;
    chk("beq_taken_pc_en", bus.pc_en, 1);
    chk("beq_pc_source", bus.pc_source, 1);
    chk("beq_alu_op", bus.alu_op, 1);
    bus.zero = 1'b0;
    #1;
    chk("beq_not_taken_pc_en", bus.pc_en, 0);
    step();
    chk("beq_back_fetch", bus.state, 0);

    // jump
    bus.opcode = 6'b000010;
    step(); step();
    chk("j_state", bus.state, 9);
    chk("j_pc_source", bus.pc_source, 2);
    chk("j_pc_en", bus.pc_en, 1);
    step();

    // illegal opcode
    bus.opcode = 6'b111111;
    step();
    chk("ill_state", bus.state, 1);
    chk("ill_flag", bus.illegal_op, 1);
    chk("ill_done", bus.instr_done, 1);
    step();
    chk("ill_back_fetch", bus.state, 0);
    chk("ill_flag_clear", bus.illegal_op, 0);

    // addi
    bus.opcode = 6'b001000;
    step(); step();
    chk("addi_iexe", bus.state, 10);
    chk("addi_alu_src_b", bus.alu_src_b, 2);
    step();
    chk("addi_iwb", bus.state, 11);
    chk("addi_reg_write", bus.reg_write, 1);
    chk("addi_reg_dst", bus.reg_dst, 0);
    step();

    // sw with one write stall
    bus.opcode = 6'b101011;
    step(); step(); step();
    bus.mem_ready = 1'b0;
    #1;
    chk("sw_memwr", bus.state, 5);
    chk("sw_mem_write", bus.mem_write, 1);
    chk("sw_stall_done", bus.instr_done, 0);
    step();
    chk("sw_hold", bus.state, 5);
    bus.mem_ready = 1'b1;
    #1;
    chk("sw_done", bus.instr_done, 1);
    step();
    chk("sw_back_fetch", bus.state, 0);

    // bne per build
    bus.opcode = 6'b000101;
    bus.zero = 1'b0;
    step();
`ifdef MIPS_MC_BNE_EN
    chk("bne_decode_legal", bus.illegal_op, 0);
    step();
    chk("bne_state", bus.state, 8);
    chk("bne_taken_pc_en", bus.pc_en, 1);
    bus.zero = 1'b1;
    #1;
    chk("bne_not_taken_pc_en", bus.pc_en, 0);
`else
    chk("bne_illegal", bus.illegal_op, 1);
    step();
    chk("bne_back_fetch", bus.state, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
